// File: rtl/param_johnson_counter_pkg.sv
// param_johnson_counter_pkg: shared mode constants and period helper for the Johnson/ring counter.
// Contents: package jc_pkg with MODE_JOHNSON/MODE_RING and jc_period(width, mode).
package jc_pkg;
    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;
    function automatic int jc_period(input int width, input int mode);
        return (mode == MODE_RING) ? width : 2 * width;
    endfunction
endpackage

// File: rtl/param_johnson_counter_if.sv
// param_johnson_counter_if: control/status bundle of the Johnson/ring counter.
// master drives en, dir, load, load_phase; slave (the counter) drives q, phase, tc, err.
interface param_johnson_counter_if
    import jc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON
);
    localparam int PW = $clog2(jc_period(WIDTH, MODE));
    logic             en;
    logic             dir;
    logic             load;
    logic [PW-1:0]    load_phase;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    phase;
    logic             tc;
    logic             err;
    modport master (output en, dir, load, load_phase, input q, phase, tc, err);
    modport slave  (input en, dir, load, load_phase, output q, phase, tc, err);
endinterface

// File: rtl/param_johnson_counter_pattern_gen.sv
// jc_pattern_gen: combinational map from phase index to the canonical counter pattern P(phase).
// Ports: i_phase (phase index), o_pat (WIDTH-bit pattern; undefined content for out-of-range phases).
module jc_pattern_gen
    import jc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON,
    localparam int PW   = $clog2(jc_period(WIDTH, MODE))
) (
    input  logic [PW-1:0]    i_phase,
    output logic [WIDTH-1:0] o_pat
);
    // Johnson: phases 0..WIDTH fill ones from the top, later phases drain them from the top.
    always_comb begin
        o_pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE == MODE_RING)
                o_pat[i] = (int'(i_phase) == WIDTH - 1 - i);
            else
                o_pat[i] = (int'(i_phase) <= WIDTH) ? (i >= WIDTH - int'(i_phase))
                                                    : (i < 2 * WIDTH - int'(i_phase));
        end
    end
endmodule

// File: rtl/param_johnson_counter.sv
// param_johnson_counter: parametrised Johnson (twisted-ring) or ring counter with phase index and wrap pulse.
// Ports: clk, reset_n (async active-low), bus (slave: en, dir, load, load_phase in; q, phase, tc, err out).
// Optional macro JC_SELF_CORRECT_EN: resynchronise to phase 0 and flag err when q drifts from P(phase).
module param_johnson_counter
    import jc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON
) (
    input logic                   clk,
    input logic                   reset_n,
    param_johnson_counter_if.slave bus
);
    localparam int PERIOD = jc_period(WIDTH, MODE);
    localparam int PW     = $clog2(PERIOD);
    localparam logic [PW-1:0]    PMAX  = PW'(PERIOD - 1);
    localparam logic [WIDTH-1:0] Q_RST = (MODE == MODE_RING) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_phase;
    logic             r_tc;
    logic             r_err;
    logic [WIDTH-1:0] w_pat_load;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic             w_load_ok;
    jc_pattern_gen #(.WIDTH(WIDTH), .MODE(MODE)) u_pat_load (
        .i_phase (bus.load_phase),
        .o_pat   (w_pat_load)
    );
`ifdef JC_SELF_CORRECT_EN
    logic [WIDTH-1:0] w_pat_cur;
    jc_pattern_gen #(.WIDTH(WIDTH), .MODE(MODE)) u_pat_cur (
        .i_phase (r_phase),
        .o_pat   (w_pat_cur)
    );
`endif
    // Ring recirculates the end bit; Johnson feeds it back inverted.
    assign w_up      = {(MODE == MODE_RING) ? r_q[0] : ~r_q[0], r_q[WIDTH-1:1]};
    assign w_dn      = {r_q[WIDTH-2:0], (MODE == MODE_RING) ? r_q[WIDTH-1] : ~r_q[WIDTH-1]};
    assign w_load_ok = 32'(bus.load_phase) < 32'(PERIOD);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= Q_RST;
            r_phase <= '0;
            r_tc    <= 1'b0;
            r_err   <= 1'b0;
        end
`ifdef JC_SELF_CORRECT_EN
        else if (r_q != w_pat_cur) begin
            r_q     <= Q_RST;
            r_phase <= '0;
            r_tc    <= 1'b0;
            r_err   <= 1'b1;
        end
`endif
        else if (bus.load) begin
            r_tc <= 1'b0;
            if (w_load_ok) begin
                r_q     <= w_pat_load;
                r_phase <= bus.load_phase;
            end else begin
                r_err <= 1'b1;
            end
        end else if (bus.en) begin
            r_q     <= bus.dir ? w_up : w_dn;
            r_phase <= bus.dir ? ((r_phase == PMAX) ? '0 : r_phase + 1'b1)
                               : ((r_phase == '0) ? PMAX : r_phase - 1'b1);
            r_tc    <= bus.dir ? (r_phase == PMAX) : (r_phase == '0);
        end else begin
            r_tc <= 1'b0;
        end
    end
    assign bus.q     = r_q;
    assign bus.phase = r_phase;
    assign bus.tc    = r_tc;
    assign bus.err   = r_err;
endmodule
